move_undo_stack: RTL

Records every cube move the driver applies and plays them back in reverse as inverse moves, returning the cube to its pre-move state. It sits beside the move engine in the cube simulator. It is written by the same face/quarter-turn pair that feeds the engine, and its output feeds the engine's move-select mux during undo. It is a LIFO with circular overwrite and a valid/ready output port.

---
 rtl/cube_pkg.sv | 36 +++
 rtl/move_undo_stack_if.sv | 35 +++
 rtl/move_lifo.sv | 63 ++++++
 rtl/move_undo_stack.sv | 105 ++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared cube-move types: field widths, rotation encodings, undo FSM states.
// inv_rot maps a recorded quarter-turn count to the move that cancels it.
package cube_pkg;

  localparam int FACE_W = 6;
  localparam int ROT_W  = 3;

  localparam logic [ROT_W-1:0] ROT_NONE = ROT_W'(0);
  localparam logic [ROT_W-1:0] ROT_CW   = ROT_W'(1);
  localparam logic [ROT_W-1:0] ROT_DBL  = ROT_W'(2);
  localparam logic [ROT_W-1:0] ROT_CCW  = ROT_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_UNDO_ONE = 2'd1,
    ST_UNDO_ALL = 2'd2
  } undo_state_t;

  typedef struct packed {
    logic [FACE_W-1:0] face;
    logic [ROT_W-1:0]  rot;
  } move_t;

  // (4 - rot) mod 4 over the legal 0..3 range
  function automatic logic [ROT_W-1:0] inv_rot(input logic [ROT_W-1:0] rot);
    logic [ROT_W-1:0] r;
    case (rot)
      ROT_CW:  r = ROT_CCW;
      ROT_CCW: r = ROT_CW;
      ROT_DBL: r = ROT_DBL;
      default: r = ROT_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/move_undo_stack_if.sv
// Record/undo/output bundle between the cube driver and the undo stack.
// master = driver + engine side, slave = move_undo_stack.
interface move_undo_stack_if #(
  parameter int DEPTH = 64
);
  import cube_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              rec_valid;
  logic [FACE_W-1:0] rec_face;
  logic [ROT_W-1:0]  rec_rot;
  logic              clear;
  logic              undo_all;
  logic              undo_one;
  logic              out_valid;
  logic              out_ready;
  logic [FACE_W-1:0] out_face;
  logic [ROT_W-1:0]  out_rot;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              lost;

  modport master (
    output rec_valid, rec_face, rec_rot, clear, undo_all, undo_one, out_ready,
    input  out_valid, out_face, out_rot, busy, count, empty, lost
  );

  modport slave (
    input  rec_valid, rec_face, rec_rot, clear, undo_all, undo_one, out_ready,
    output out_valid, out_face, out_rot, busy, count, empty, lost
  );

endinterface

// File: rtl/move_lifo.sv
// Circular LIFO of moves: push at wr_ptr, pop from wr_ptr-1, top read combinational.
// One push or pop per cycle; full pushes overwrite the oldest entry and set sticky lost.
module move_lifo
  import cube_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  move_t                      i_push_dat,
  input  logic                       i_pop,
  output move_t                      o_top_dat,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_lost
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  move_t              r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_lost;
  logic               w_full;

  assign w_full = (r_count == CNT_W'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_lost   <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_lost   <= 1'b0;
    end else if (i_push) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      // A full ring keeps its count; the slot just written was the oldest move
      if (w_full) begin
        r_lost <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop) begin
      r_wr_ptr <= r_wr_ptr - PTR_W'(1);
      r_count  <= r_count - CNT_W'(1);
    end
  end

  assign o_top_dat = r_mem[r_wr_ptr - PTR_W'(1)];
  assign o_count   = r_count;
  assign o_lost    = r_lost;

endmodule

// File: rtl/move_undo_stack.sv
// Records applied cube moves and replays their inverses newest-first on undo_one/undo_all.
// out_valid rises one cycle after an accepted request; outputs hold under out_ready low, one pop per cycle.
module move_undo_stack
  import cube_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  move_undo_stack_if.slave       bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  undo_state_t        r_state;
  logic               r_out_valid;
  logic               r_busy;
  logic               w_idle;
  logic               w_push;
  logic               w_pop;
  logic               w_have;
  logic               w_last;
  logic [CNT_W-1:0]   w_count;
  logic               w_lost;
  move_t              w_push_dat;
  move_t              w_top;

  assign w_idle = (r_state == ST_IDLE);
  // Recording is frozen while busy so replayed inverses are not captured again
  assign w_push = w_idle & bus.rec_valid & (bus.rec_rot != ROT_NONE) & ~bus.clear;
  assign w_pop  = r_out_valid & bus.out_ready & ~bus.clear;
  assign w_have = (w_count != '0) | w_push;
  assign w_last = (w_count == CNT_W'(1));

  assign w_push_dat.face = bus.rec_face;
  assign w_push_dat.rot  = bus.rec_rot;

  move_lifo #(
    .DEPTH (DEPTH)
  ) u_lifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (bus.clear),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_top_dat  (w_top),
    .o_count    (w_count),
    .o_lost     (w_lost)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.clear) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.undo_all && w_have) begin
            r_state     <= ST_UNDO_ALL;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end else if (bus.undo_one && w_have) begin
            r_state     <= ST_UNDO_ONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_UNDO_ONE: begin
          if (w_pop) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        ST_UNDO_ALL: begin
          if (w_pop && w_last) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_face  = r_out_valid ? w_top.face : '0;
  assign bus.out_rot   = r_out_valid ? inv_rot(w_top.rot) : '0;
  assign bus.busy      = r_busy;
  assign bus.count     = w_count;
  assign bus.empty     = (w_count == '0);
  assign bus.lost      = w_lost;

endmodule
